// File: rtl/stream_seq_checker_if.sv
// Valid/ready stream carrying the words under test into the sequence checker.
interface stream_seq_checker_if #(
   parameter int DSIZE = 8
);
   logic [DSIZE-1:0] idata;
   logic             ivalid;
   logic             iready;

   modport master (output idata, output ivalid, input iready);
   modport slave  (input idata, input ivalid, output iready);
endinterface

// File: rtl/stream_seq_checker.sv
// Checks an incoming stream against prev + STEP (mod 2^DSIZE): acquires lock,
// flags and counts mismatches, and falls back to searching after repeated misses.
module stream_seq_checker #(
   parameter int DSIZE  = 8,
   parameter int STEP   = 1,
   parameter int LOCK_N = 4,
   parameter int LOST_N = 3,
   parameter int CNT_W  = 16
) (
   input  logic                 sys_clock,
   input  logic                 sys_rst,
   stream_seq_checker_if.slave  s_in,
   input  logic                 clr_cnt,
   output logic                 locked,
   output logic                 err_pulse,
   output logic [CNT_W-1:0]     err_cnt,
   output logic [CNT_W-1:0]     word_cnt
);

   localparam int MATCH_W = $clog2(LOCK_N + 1);
   localparam int MISS_W  = $clog2(LOST_N + 1);
   localparam logic [DSIZE-1:0]   STEP_V    = DSIZE'(STEP);
   localparam logic [MATCH_W-1:0] LOCK_LAST = MATCH_W'(LOCK_N - 1);
   localparam logic [MISS_W-1:0]  MISS_LAST = MISS_W'(LOST_N - 1);
   // With LOCK_N=1 a freshly seeded word already satisfies the lock condition.
   localparam bit LOCK_ON_SEED = (LOCK_N == 1);

   typedef enum logic [1:0] {IDLE, SEARCH, LOCKED} state_t;

   state_t             state_reg;
   logic [DSIZE-1:0]   expected_reg;
   logic [MATCH_W-1:0] match_cnt_reg;
   logic [MISS_W-1:0]  miss_cnt_reg;
   logic               iready_reg;
   logic               locked_reg;
   logic               err_pulse_reg;
   logic [CNT_W-1:0]   err_cnt_reg;
   logic [CNT_W-1:0]   word_cnt_reg;

   logic               beat;
   logic               hit;
   logic [DSIZE-1:0]   seed_next;
   logic [DSIZE-1:0]   advance_next;

   assign beat         = s_in.ivalid & iready_reg;
   assign hit          = (s_in.idata == expected_reg);
   assign seed_next    = s_in.idata + STEP_V;
   assign advance_next = expected_reg + STEP_V;

   always_ff @(posedge sys_clock) begin
      if (sys_rst) begin
         state_reg     <= IDLE;
         expected_reg  <= '0;
         match_cnt_reg <= '0;
         miss_cnt_reg  <= '0;
         iready_reg    <= 1'b0;
         locked_reg    <= 1'b0;
         err_pulse_reg <= 1'b0;
         err_cnt_reg   <= '0;
         word_cnt_reg  <= '0;
      end else begin
         iready_reg    <= 1'b1;
         err_pulse_reg <= 1'b0;
         if (beat) begin
            if (word_cnt_reg != {CNT_W{1'b1}})
               word_cnt_reg <= word_cnt_reg + CNT_W'(1);
            unique case (state_reg)
               IDLE: begin
                  expected_reg  <= seed_next;
                  match_cnt_reg <= MATCH_W'(1);
                  state_reg     <= LOCK_ON_SEED ? LOCKED : SEARCH;
                  locked_reg    <= LOCK_ON_SEED;
               end
               SEARCH: begin
                  if (hit) begin
                     expected_reg  <= advance_next;
                     match_cnt_reg <= match_cnt_reg + MATCH_W'(1);
                     if (match_cnt_reg == LOCK_LAST) begin
                        state_reg    <= LOCKED;
                        locked_reg   <= 1'b1;
                        miss_cnt_reg <= '0;
                     end
                  end else begin
                     expected_reg  <= seed_next;
                     match_cnt_reg <= MATCH_W'(1);
                     state_reg     <= LOCK_ON_SEED ? LOCKED : SEARCH;
                     locked_reg    <= LOCK_ON_SEED;
                  end
               end
               LOCKED: begin
                  // Free-running: a single corrupted word must not shift the sequence.
                  expected_reg <= advance_next;
                  if (hit) begin
                     miss_cnt_reg <= '0;
                  end else begin
                     err_pulse_reg <= 1'b1;
                     if (err_cnt_reg != {CNT_W{1'b1}})
                        err_cnt_reg <= err_cnt_reg + CNT_W'(1);
                     if (miss_cnt_reg == MISS_LAST) begin
                        state_reg     <= LOCK_ON_SEED ? LOCKED : SEARCH;
                        locked_reg    <= LOCK_ON_SEED;
                        expected_reg  <= seed_next;
                        match_cnt_reg <= MATCH_W'(1);
                        miss_cnt_reg  <= '0;
                     end else begin
                        miss_cnt_reg <= miss_cnt_reg + MISS_W'(1);
                     end
                  end
               end
               default: state_reg <= IDLE;
            endcase
         end
         if (clr_cnt) begin
            err_cnt_reg  <= '0;
            word_cnt_reg <= '0;
         end
      end
   end

   assign s_in.iready = iready_reg;
   assign locked      = locked_reg;
   assign err_pulse   = err_pulse_reg;
   assign err_cnt     = err_cnt_reg;
   assign word_cnt    = word_cnt_reg;

endmodule

// File: doc/stream_seq_checker.md
Name: stream_seq_checker

Overview:
Receive-side counterpart of the `test_top` data source: it consumes the data stream `test_top` drives on `odata` and checks it against an arithmetic sequence (prev + STEP, modulo 2^DSIZE). It acquires lock on the sequence, flags and counts mismatches, and declares loss of lock after repeated misses. It is instantiated beside `test_top` in top-level testbenches and in on-board loopback builds.

Parameters:
DSIZE, 8, data width in bits.
STEP, 1, expected increment between consecutive accepted words, taken modulo 2^DSIZE.
LOCK_N, 4, consecutive matching words required to go from SEARCH to LOCKED (legal range ≥1).
LOST_N, 3, consecutive mismatching words in LOCKED that force a return to SEARCH (legal range ≥1).
CNT_W, 16, width of the error and word counters.

Ports:
sys_clock  input  1  single clock; all logic on the rising edge.
sys_rst  input  1  synchronous, active-high reset.
idata  input  DSIZE  incoming data word.
ivalid  input  1  idata is valid this cycle.
iready  output  1  checker can accept; a beat is accepted when ivalid & iready.
clr_cnt  input  1  synchronous clear of err_cnt and word_cnt.
locked  output  1  high while in LOCKED state.
err_pulse  output  1  one-cycle pulse per mismatching beat accepted in LOCKED.
err_cnt  output  CNT_W  saturating count of mismatches flagged via err_pulse.
word_cnt  output  CNT_W  saturating count of accepted beats.

Behaviour:
- Reset (sys_rst=1 at a clock edge): state=IDLE; iready=0, locked=0, err_pulse=0, err_cnt=0, word_cnt=0, expected=0, match/miss counters=0. Reset mid-stream discards all state; the beat present on that edge is not accepted.
- iready is a register: 0 in reset, then 1 from the first cycle after sys_rst deasserts. It never applies backpressure.
- All outputs are registered and update 1 cycle after the accepted beat; cycles without a beat leave state unchanged and err_pulse=0.
- expected_next = idata_or_expected + STEP, truncated to DSIZE bits (wrap e.g. 8'hFF+1 → 8'h00).
- IDLE: the first accepted beat seeds expected = idata+STEP and sets match_cnt=1. If LOCK_N=1, go to LOCKED; otherwise go to SEARCH.
- SEARCH, accepted beat:
  - idata==expected: match_cnt++, expected+=STEP; when match_cnt reaches LOCK_N, go to LOCKED and set locked=1.
  - mismatch: reseed expected = idata+STEP and set match_cnt=1. No err_pulse, no err_cnt change.
- LOCKED, accepted beat: expected always advances from expected (free-running), never from idata.
  - match: miss_cnt=0.
  - mismatch: err_pulse=1, err_cnt++ (saturates at all-ones), miss_cnt++. When miss_cnt reaches LOST_N: go to SEARCH, locked=0, reseed expected=idata+STEP, match_cnt=1, miss_cnt=0.
  - Consequence: one corrupted word yields exactly one error and lock is kept. A dropped or duplicated word yields LOST_N errors, then resync.
- word_cnt increments on every accepted beat in any state and saturates at all-ones.
- clr_cnt: both counters go to 0. If a beat is accepted in the same cycle, clear wins (counter=0, not 1). clr_cnt does not affect state, locked, or expected.
- err_pulse is never asserted outside LOCKED.

Test Plan:
- Reset then feed 0,1,2,3,4,… continuously → iready=1 from the cycle after reset; locked rises 1 cycle after the 4th beat (value 3); err_cnt stays 0; word_cnt=N after N beats.
- After lock, feed …,9,0x55,11,12 → exactly one err_pulse, 1 cycle after 0x55; err_cnt=1; locked stays 1.
- After lock, drop value 20 (feed 19,21,22,23,24,25,26,27) → 3 err_pulses on 21,22,23; locked=0 after 23; locked=1 again 1 cycle after beat 26 (seed 23 + matches 24,25,26); err_cnt=3.
- DSIZE=8: feed 0xFC through 0x03 → lock acquired across the 0xFF→0x00 wrap with no errors. Repeat with STEP=3: 0xFA,0xFD,0x00,0x03 → lock, no errors.
- Assert sys_rst while LOCKED with err_cnt=5 → next cycle all outputs 0, iready=0; after release the sequence restarting at 0x40 re-locks after 4 beats.
- Assert clr_cnt together with an accepted mismatching beat in LOCKED → err_pulse=1 but err_cnt=0 and word_cnt=0. Separately, force err_cnt to 0xFFFF with CNT_W=16 plus one more error → err_cnt holds at 0xFFFF.
